mite_loader: RTL

Upstream program loader for the 8-bit accumulator core. Accepts a byte stream over a valid/ready handshake, assembles 10-bit instruction words and writes them sequentially into the core's 256×10 program memory. After a checksum-verified image it asserts `cpu_run`, which releases the core from its hold. It replaces the fixed hex-file preload for in-system reprogramming.

---
 rtl/mite_loader_if.sv | 40 ++++
 rtl/mite_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/mite_loader_if.sv
// Byte-stream and program-memory bundle for the mite program loader.
// The slave side is the loader; the master side drives the stream.
interface mite_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_req;
  logic       pm_we;
  logic [7:0] pm_addr;
  logic [9:0] pm_wdata;
  logic       cpu_run;
  logic       done;
  logic       error;

  modport slave (
    input  in_valid,
    input  in_data,
    input  load_req,
    output in_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata,
    output cpu_run,
    output done,
    output error
  );

  modport master (
    output in_valid,
    output in_data,
    output load_req,
    input  in_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata,
    input  cpu_run,
    input  done,
    input  error
  );
endinterface

// File: rtl/mite_loader.sv
// Program loader: assembles 10-bit words from a byte stream,
// writes them to program memory, and releases the core on a good checksum.
module mite_loader (
  input logic          clk,
  input logic          reset_n,
  mite_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] lo_q, lo_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [9:0] wdata_q, wdata_d;

  logic       acc;
  logic [7:0] sum_add;

  assign bus.in_ready = (state_q != S_DONE) &&
                        (state_q != S_ERR);
  assign acc     = bus.in_valid && bus.in_ready;
  assign sum_add = sum_q + bus.in_data;

  assign bus.pm_we    = we_q;
  assign bus.pm_addr  = addr_q;
  assign bus.pm_wdata = wdata_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.cpu_run  = (state_q == S_DONE);
  assign bus.error    = (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          // A zero header encodes a full 256-word image
          cnt_d   = (bus.in_data == 8'd0) ? 9'd256
                  : {1'b0, bus.in_data};
          idx_d   = 9'd0;
          sum_d   = 8'd0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (acc) begin
          lo_d    = bus.in_data;
          sum_d   = sum_add;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (acc) begin
          if (|bus.in_data[7:2]) begin
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = idx_q[7:0];
            wdata_d = {bus.in_data[1:0], lo_q};
            sum_d   = sum_add;
            idx_d   = idx_q + 9'd1;
            state_d = (idx_d == cnt_q) ? S_CSUM
                    : S_LO;
          end
        end
      end
      S_CSUM: begin
        if (acc) begin
          state_d = (sum_add == 8'd0) ? S_DONE
                  : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.load_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 9'd0;
      idx_q   <= 9'd0;
      sum_q   <= 8'd0;
      lo_q    <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 10'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
